scoreboard_multi_fu: RTL and testbench
======================================

Name: scoreboard_multi_fu

Overview:
- Parametrised register scoreboard for the in-order-issue, out-of-order-completion core. Generalises the fixed three-unit (ALU/MUL/LSU) scoreboard to NUM_FU functional units, each allowing up to FU_DEPTH outstanding operations.
- Sits between instruction decode and the per-unit issue stages. Per issued instruction it decides issue/stall, reports the operand dependency tags, and tracks pending destination writes until writeback.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero, never busy.
- NUM_FU, 3, functional-unit channels (index 0=ALU, 1=MUL, 2=LSU by convention).
- FU_DEPTH, 2, max in-flight ops per unit (1..7).
- REG_W, $clog2(NUM_REGS), register index width (derived).
- FU_W, $clog2(NUM_FU) (min 1), unit index width (derived).
- CNT_W, $clog2(FU_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all tracking (restart / OS reload).
- issue_valid  in  1  decoded instruction present.
- issue_fu  in  FU_W  target unit index.
- issue_rd  in  REG_W  destination register.
- issue_rd_we  in  1  instruction writes rd (0 for stores/branches).
- issue_rs1  in  REG_W  source 1.
- issue_rs2  in  REG_W  source 2.
- issue_ready  out  1  instruction accepted this cycle (combinational).
- stall  out  1  issue_valid & !issue_ready.
- rs1_pending  out  1  rs1 value not yet available.
- rs1_tag  out  FU_W  producing unit for rs1 (valid when rs1_pending).
- rs2_pending  out  1  as rs1.
- rs2_tag  out  FU_W  as rs1.
- wb_valid  in  NUM_FU  per-unit writeback strobe.
- wb_rd  in  NUM_FU*REG_W  per-unit writeback register, unit i at [i*REG_W +: REG_W].
- fu_busy  out  NUM_FU  unit i counter == FU_DEPTH.
- idle  out  1  no register busy and all counters zero.
- err_underflow  out  1  sticky: writeback on unit with zero count, or on non-busy/wrong-owner rd.

Behaviour:
- Reset: all outputs and state deasserted.
  - busy[] = 0, owner[] = 0, cnt[] = 0, err_underflow = 0.
  - idle = 1 (combinational from state).
- State: busy bit + owner tag per register (index 0 excluded); CNT_W counter per unit.
- Writeback (per unit i, same cycle for multiple units allowed):
  - if wb_valid[i]: cnt[i] decrements.
  - if busy[wb_rd_i] and owner == i, clear busy; otherwise set err_underflow.
  - wb_valid[i] with cnt[i]==0 also sets err_underflow; counter saturates at 0.
- Issue accepted (issue_ready) when all hold:
  - issue_valid = 1;
  - issue_fu < NUM_FU;
  - cnt[issue_fu] < FU_DEPTH, or that unit writes back this cycle;
  - no WAW: !(issue_rd_we & issue_rd!=0 & busy[issue_rd]), unless owner's wb_valid targets issue_rd this cycle.
- On accept: cnt[issue_fu]++; if issue_rd_we & rd!=0: busy[rd]=1, owner[rd]=issue_fu.
- Operand tags (combinational, evaluated even when stalling):
  - rsX_pending = busy[rsX] & !(wb_valid[owner] & wb_rd_owner == rsX).
  - Writeback-this-cycle counts as available (register file write-through).
  - rsX_tag = owner[rsX]. rsX==0 never pending.
- RAW is not a stall: the issue stage waits on the tag. Stall only for WAW or no credit.
- Same-cycle priority: writeback clears apply first, then issue sets.
  - Issue to the register being freed ends busy with the new owner.
  - Issue and writeback on the same unit leave cnt unchanged.
- flush: next edge clears busy/owner/cnt; err_underflow kept; issue and writeback that cycle are ignored.
- Reset mid-operation: immediate asynchronous clear of everything; in-flight writebacks after reset raise err_underflow (bench drains units first).
- Single issue per cycle; zero-cycle latency from state to issue_ready.

Decomposition:
- Shared package: FU index localparams (FU_ALU=0, FU_MUL=1, FU_LSU=2), derived-width functions, register-zero constant.
- Sub-module fu_credit_counter: one per unit via generate; inc/dec/flush, outputs count and full, saturating with underflow flag.
- Register busy/owner array and hazard logic stay in the top.

Test Plan:
- Reset, issue_valid=1 fu=0 rd=5 we=1 rs1=rs2=0 -> issue_ready=1; next cycle busy[5], idle=0, fu_busy=000.
- Issue rd=5 on fu=1, then rs1=5 on fu=0 -> accepted with rs1_pending=1, rs1_tag=1. Assert wb_valid[1], wb_rd=5 -> same-cycle rs1_pending=0, busy[5] cleared next edge.
- FU_DEPTH=2: two issues to fu=2 (rd=7, rd=8) -> fu_busy[2]=1. Third issue to fu=2 -> stall=1. Same cycle add wb_valid[2], rd=7 -> third accepted, cnt[2] stays 2.
- WAW: rd=9 busy on fu=0, issue rd=9 on fu=1 -> stall. Pulse wb_valid[0], rd=9 that cycle -> accepted; owner[9]=1, busy stays 1.
- Writes to x0: issue rd=0 we=1 -> accepted, busy[0] never set, rs1=0 never pending.
- Flush with 3 busy regs and cnt={1,1,1} -> next cycle idle=1. Later wb_valid[0] -> err_underflow=1 and stays set until rst_n=0.

Source files
------------

// File: rtl/scoreboard_multi_fu_pkg.sv
// Shared constants and width helpers for the multi-unit register scoreboard.
package scoreboard_multi_fu_pkg;

    localparam int FU_ALU   = 0;
    localparam int FU_MUL   = 1;
    localparam int FU_LSU   = 2;
    localparam int REG_ZERO = 0;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scoreboard_multi_fu_credit_counter.sv
// Per-unit in-flight credit counter; saturates at zero and flags underflow.
module fu_credit_counter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        underflow = dec && (cnt_q == '0) && !flush;
        cnt_d     = cnt_q;
        if (flush)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec && (cnt_q != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/scoreboard_multi_fu.sv
// Register scoreboard for NUM_FU out-of-order-completing units: issue/stall
// decision, operand producer tags, and pending-write tracking until writeback.
module scoreboard_multi_fu
    import scoreboard_multi_fu_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_FU   = 3,
    parameter int FU_DEPTH = 2,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int FU_W     = idx_w(NUM_FU),
    parameter int CNT_W    = $clog2(FU_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [FU_W-1:0]           issue_fu,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic                      issue_rd_we,
    input  logic [REG_W-1:0]          issue_rs1,
    input  logic [REG_W-1:0]          issue_rs2,
    output logic                      issue_ready,
    output logic                      stall,
    output logic                      rs1_pending,
    output logic [FU_W-1:0]           rs1_tag,
    output logic                      rs2_pending,
    output logic [FU_W-1:0]           rs2_tag,
    input  logic [NUM_FU-1:0]         wb_valid,
    input  logic [NUM_FU*REG_W-1:0]   wb_rd,
    output logic [NUM_FU-1:0]         fu_busy,
    output logic                      idle,
    output logic                      err_underflow
);

    // Per-unit views padded to the full FU_W index space so out-of-range
    // unit indices read as "no writeback, not full" instead of X.
    localparam int FU_N = 1 << FU_W;

    logic [NUM_REGS-1:0]                busy_q, busy_d;
    logic [NUM_REGS-1:0][FU_W-1:0]      owner_q, owner_d;
    logic                               err_q, err_d;
    logic [FU_N-1:0]                    wbv_pad, full_pad;
    logic [FU_N-1:0][REG_W-1:0]         wbrd_pad;
    logic [NUM_FU-1:0]                  full, uf;
    logic [NUM_FU-1:0][CNT_W-1:0]       cnt;
    logic                               fu_ok, rd_pend, accept;

    always_comb begin
        wbv_pad  = '0;
        full_pad = '0;
        wbrd_pad = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            wbv_pad[i]  = wb_valid[i];
            full_pad[i] = full[i];
            wbrd_pad[i] = wb_rd[i*REG_W +: REG_W];
        end
    end

    // Busy and not being released by its owner's writeback this cycle.
    function automatic logic reg_pending(input logic [REG_W-1:0] r);
        return (r != REG_W'(REG_ZERO)) && busy_q[r] &&
               !(wbv_pad[owner_q[r]] && (wbrd_pad[owner_q[r]] == r));
    endfunction

    always_comb begin
        rs1_pending = reg_pending(issue_rs1);
        rs2_pending = reg_pending(issue_rs2);
        rs1_tag     = owner_q[issue_rs1];
        rs2_tag     = owner_q[issue_rs2];
        rd_pend     = reg_pending(issue_rd);
        fu_ok       = 32'(issue_fu) < NUM_FU;
        issue_ready = issue_valid && !flush && fu_ok &&
                      (!full_pad[issue_fu] || wbv_pad[issue_fu]) &&
                      !(issue_rd_we && rd_pend);
        accept      = issue_ready;
        stall       = issue_valid && !issue_ready;
    end

    // Writeback clears land first so a same-cycle issue to the freed register wins.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        err_d   = err_q || (|uf);
        if (!flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (wb_valid[i]) begin
                    if (busy_q[wbrd_pad[i]] && owner_q[wbrd_pad[i]] == FU_W'(i))
                        busy_d[wbrd_pad[i]] = 1'b0;
                    else
                        err_d = 1'b1;
                end
            end
            if (accept && issue_rd_we && issue_rd != REG_W'(REG_ZERO)) begin
                busy_d[issue_rd]  = 1'b1;
                owner_d[issue_rd] = issue_fu;
            end
        end else begin
            busy_d  = '0;
            owner_d = '0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_cnt
        fu_credit_counter #(
            .DEPTH (FU_DEPTH),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .inc       (accept && (issue_fu == FU_W'(g))),
            .dec       (wb_valid[g]),
            .cnt       (cnt[g]),
            .full      (full[g]),
            .underflow (uf[g])
        );
    end

    assign fu_busy       = full;
    assign idle          = !(|busy_q) && !(|cnt);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_scoreboard_multi_fu.sv
// Directed bench: each stimulus cycle queues its hand-computed expectation,
// a negedge monitor pops and compares against the DUT outputs.
module tb_scoreboard_multi_fu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_fu = '0;
    logic [4:0]  issue_rd = '0;
    logic        issue_rd_we = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic        issue_ready, stall, rs1_pending, rs2_pending, idle, err_underflow;
    logic [1:0]  rs1_tag, rs2_tag;
    logic [2:0]  wb_valid = '0;
    logic [14:0] wb_rd = '0;
    logic [2:0]  fu_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      nm;
        bit         rdy;
        bit         stl;
        bit         p1;
        logic [1:0] t1;
        bit         p2;
        logic [1:0] t2;
        logic [2:0] fb;
        bit         idl;
        bit         err;
    } exp_t;

    exp_t exp_q[$];

    scoreboard_multi_fu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_fu      (issue_fu),
        .issue_rd      (issue_rd),
        .issue_rd_we   (issue_rd_we),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_ready   (issue_ready),
        .stall         (stall),
        .rs1_pending   (rs1_pending),
        .rs1_tag       (rs1_tag),
        .rs2_pending   (rs2_pending),
        .rs2_tag       (rs2_tag),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .fu_busy       (fu_busy),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string nm, input bit rn, input bit fl,
                       input bit v, input int fu, input int rd, input bit we,
                       input int rs1, input int rs2,
                       input bit [2:0] wbv, input int w0, input int w1, input int w2,
                       input bit e_rdy, input bit e_p1, input int e_t1,
                       input bit e_p2, input int e_t2,
                       input bit [2:0] e_fb, input bit e_idl, input bit e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rn;
        flush       = fl;
        issue_valid = v;
        issue_fu    = 2'(fu);
        issue_rd    = 5'(rd);
        issue_rd_we = we;
        issue_rs1   = 5'(rs1);
        issue_rs2   = 5'(rs2);
        wb_valid    = wbv;
        wb_rd       = {5'(w2), 5'(w1), 5'(w0)};
        e.nm  = nm;
        e.rdy = e_rdy;
        e.stl = v && !e_rdy;
        e.p1  = e_p1;
        e.t1  = 2'(e_t1);
        e.p2  = e_p2;
        e.t2  = 2'(e_t2);
        e.fb  = e_fb;
        e.idl = e_idl;
        e.err = e_err;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (issue_ready !== e.rdy || stall !== e.stl ||
                    rs1_pending !== e.p1 || (e.p1 && rs1_tag !== e.t1) ||
                    rs2_pending !== e.p2 || (e.p2 && rs2_tag !== e.t2) ||
                    fu_busy !== e.fb || idle !== e.idl || err_underflow !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got rdy=%b stall=%b p1=%b t1=%0d p2=%b t2=%0d fb=%b idle=%b err=%b, want rdy=%b stall=%b p1=%b t1=%0d p2=%b t2=%0d fb=%b idle=%b err=%b",
                             e.nm, issue_ready, stall, rs1_pending, rs1_tag, rs2_pending, rs2_tag,
                             fu_busy, idle, err_underflow,
                             e.rdy, e.stl, e.p1, e.t1, e.p2, e.t2, e.fb, e.idl, e.err);
                end
            end
        end
    end

    initial begin : stim
        //  name            rn fl v fu rd we rs1 rs2 wbv    w0 w1 w2   rdy p1 t1 p2 t2 fb     idl err
        cyc("reset",        0, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("bad_fu",       1, 0, 1, 3, 1, 1, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t1_issue",     1, 0, 1, 0, 5, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t1_state",     1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t1_wb",        1, 0, 0, 0, 0, 0, 0,  0, 3'b001, 5, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t2_issue_mul", 1, 0, 1, 1, 5, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t2_raw",       1, 0, 1, 0, 6, 1, 5,  0, 3'b000, 0, 0, 0,  1,  1, 1, 0, 0, 3'b000, 0, 0);
        cyc("t2_wb_fwd",    1, 0, 0, 0, 0, 0, 5,  6, 3'b010, 0, 5, 0,  0,  0, 0, 1, 0, 3'b000, 0, 0);
        cyc("t2_cleared",   1, 0, 0, 0, 0, 0, 5,  6, 3'b000, 0, 0, 0,  0,  0, 0, 1, 0, 3'b000, 0, 0);
        cyc("t2_drain",     1, 0, 0, 0, 0, 0, 0,  0, 3'b001, 6, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t3_a",         1, 0, 1, 2, 7, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t3_b",         1, 0, 1, 2, 8, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t3_stall",     1, 0, 1, 2, 10, 1, 0, 0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b100, 0, 0);
        cyc("t3_wb_credit", 1, 0, 1, 2, 10, 1, 0, 0, 3'b100, 0, 0, 7,  1,  0, 0, 0, 0, 3'b100, 0, 0);
        cyc("t3_still_full",1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b100, 0, 0);
        cyc("t3_drain",     1, 0, 0, 0, 0, 0, 0,  0, 3'b100, 0, 0, 8,  0,  0, 0, 0, 0, 3'b100, 0, 0);
        cyc("t3_drain2",    1, 0, 0, 0, 0, 0, 0,  0, 3'b100, 0, 0, 10, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t4_a",         1, 0, 1, 0, 9, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t4_waw",       1, 0, 1, 1, 9, 1, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t4_waw_wb",    1, 0, 1, 1, 9, 1, 0,  0, 3'b001, 9, 0, 0,  1,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t4_owner",     1, 0, 0, 0, 0, 0, 9,  0, 3'b000, 0, 0, 0,  0,  1, 1, 0, 0, 3'b000, 0, 0);
        cyc("t4_drain",     1, 0, 0, 0, 0, 0, 9,  0, 3'b010, 0, 9, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t5_x0",        1, 0, 1, 0, 0, 1, 0,  0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t5_after",     1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t5_flush",     1, 1, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t5_flushed",   1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t6_a",         1, 0, 1, 0, 11, 1, 0, 0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t6_b",         1, 0, 1, 1, 12, 1, 0, 0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t6_c",         1, 0, 1, 2, 13, 1, 0, 0, 3'b000, 0, 0, 0,  1,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t6_flush",     1, 1, 1, 0, 14, 1, 0, 0, 3'b010, 0, 12, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        cyc("t6_idle",      1, 0, 0, 0, 0, 0, 11, 0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t7_uf",        1, 0, 0, 0, 0, 0, 0,  0, 3'b001, 11, 0, 0, 0,  0, 0, 0, 0, 3'b000, 1, 0);
        cyc("t7_err",       1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 1);
        cyc("t7_sticky",    1, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 1);
        cyc("t8_reset",     0, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
